// File: rtl/banked_mem_resp_pkg.sv
// Shared constants for the four-bank interleaved memory responder.
// Address layout: [0] byte offset (must be 0), [2:1] bank, [ROW_BITS+2:3] row.
package banked_mem_resp_pkg;
   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 16;
   localparam int ROW_BITS = 13;
   localparam int BUSY_CYC = 4;
   localparam int RD_LAT   = 2;
   localparam int N_BANKS  = 4;
   localparam int BANK_LSB = 1;
   localparam int BANK_W   = 2;
   localparam int ROW_LSB  = 3;
   localparam int CNT_W    = $clog2(BUSY_CYC);

   typedef logic [BANK_W-1:0] bank_t;

   function automatic bank_t bank_of(input logic [ADDR_W-1:0] a);
      return a[BANK_LSB +: BANK_W];
   endfunction
endpackage

// File: rtl/banked_mem_resp_mem_bank.sv
// One word bank: storage array with registered read, write port and occupancy counter.
// The read register is only loaded on a read accept, so it holds its word while the bank is busy.
module mem_bank
   import banked_mem_resp_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_acc,
   input  logic                i_we,
   input  logic [ROW_BITS-1:0] i_row,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic [DATA_W-1:0]   o_rdata,
   output logic                o_busy
);
   logic [DATA_W-1:0] r_mem [2**ROW_BITS];
   logic [DATA_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_cnt;

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_acc && i_we) begin
         r_mem[i_row] <= i_wdata;
      end
      if (i_acc && !i_we) begin
         r_rdata <= r_mem[i_row];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_acc) begin
         r_cnt <= CNT_W'(BUSY_CYC - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_rdata = r_rdata;
   assign o_busy  = (r_cnt != '0);
endmodule

// File: rtl/banked_mem_resp.sv
// Memory-side responder: request decode, err/stall generation, four interleaved
// banks and the read return pipeline (bank tag + data, fixed RD_LAT latency).
module banked_mem_resp
   import banked_mem_resp_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [DATA_W-1:0]  i_data_in,
   input  logic               i_wr,
   input  logic               i_rd,
   output logic [DATA_W-1:0]  o_data_out,
   output logic               o_data_valid,
   output logic               o_stall,
   output logic [N_BANKS-1:0] o_busy,
   output logic               o_err
);
   logic                w_req;
   logic                w_illegal;
   logic                w_legal;
   logic                w_accept;
   logic                w_rd_acc;
   bank_t               w_bank;
   logic [ROW_BITS-1:0] w_row;
   logic [N_BANKS-1:0]  w_busy;
   logic [N_BANKS-1:0]  w_bank_acc;
   logic [DATA_W-1:0]   w_bank_rdata [N_BANKS];

   logic [RD_LAT-1:0]   r_vld;
   bank_t               r_tag [RD_LAT-1];
   logic [DATA_W-1:0]   r_dout;

   assign w_req     = i_rd | i_wr;
   assign w_illegal = (i_rd & i_wr) | (w_req & i_addr[0]);
   assign w_legal   = w_req & ~w_illegal;
   assign w_bank    = bank_of(i_addr);
   assign w_row     = i_addr[ROW_LSB +: ROW_BITS];
   assign w_accept  = w_legal & ~w_busy[w_bank];
   assign w_rd_acc  = w_accept & i_rd;

   assign o_err     = w_illegal;
   assign o_stall   = w_legal & w_busy[w_bank];
   assign o_busy    = w_busy;

   for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
      assign w_bank_acc[gi] = w_accept && (w_bank == bank_t'(gi));

      mem_bank u_bank (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_acc   (w_bank_acc[gi]),
         .i_we    (i_wr),
         .i_row   (w_row),
         .i_wdata (i_data_in),
         .o_rdata (w_bank_rdata[gi]),
         .o_busy  (w_busy[gi])
      );
   end

   // Stage 1 data lives in the selected bank's read register; the tag picks it up.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld <= '0;
      end else begin
         r_vld <= {r_vld[RD_LAT-2:0], w_rd_acc};
      end
   end

   always_ff @(posedge i_clk) begin
      r_tag[0] <= w_bank;
      for (int i = 1; i < RD_LAT - 1; i++) begin
         r_tag[i] <= r_tag[i-1];
      end
      r_dout <= w_bank_rdata[r_tag[RD_LAT-2]];
   end

   assign o_data_valid = r_vld[RD_LAT-1];
   assign o_data_out   = r_vld[RD_LAT-1] ? r_dout : '0;
endmodule

// File: tb/tb_banked_mem_resp.sv
// Scenario bench for banked_mem_resp: reads are scoreboarded with their expected
// completion cycle and checked every cycle as the pipeline drains.
module tb_banked_mem_resp;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        wr;
   logic        rd;
   logic [15:0] data_out;
   logic        data_valid;
   logic        stall;
   logic [3:0]  busy;
   logic        err;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] model [int];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   banked_mem_resp dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_addr       (addr),
      .i_data_in    (data_in),
      .i_wr         (wr),
      .i_rd         (rd),
      .o_data_out   (data_out),
      .o_data_valid (data_valid),
      .o_stall      (stall),
      .o_busy       (busy),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      rd      = r;
      wr      = w;
      addr    = a;
      data_in = d;
      #1;
   endtask

   // Advance one cycle and compare the return path against the scoreboard head.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      rd = 1'b0;
      wr = 1'b0;
      checks++;
      if (data_valid) begin
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: cycle %0d data_valid=1 data_out=%h, required data_valid=0", cyc, data_out);
         end else begin
            e = sbq.pop_front();
            if (data_out !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL sb_read: cycle %0d data_out=%h, required cycle %0d data %h", cyc, data_out, e.cyc, e.data);
            end else begin
               $display("read done cycle %0d data %h", cyc, data_out);
            end
         end
      end else begin
         if (data_out !== 16'h0) begin
            errors++;
            $display("FAIL idle_data: cycle %0d data_out=%h, required 0000", cyc, data_out);
         end
         if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            errors++;
            $display("FAIL sb_missing: cycle %0d data_valid=0, required data %h due cycle %0d", cyc, sbq[0].data, sbq[0].cyc);
            void'(sbq.pop_front());
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      tick();
      checks++;
      if (data_out !== 16'h0 || data_valid !== 1'b0 || busy !== 4'h0 || stall !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: data_out=%h valid=%b busy=%b stall=%b err=%b, required all 0",
                  data_out, data_valid, busy, stall, err);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_bank_stream();
      logic [15:0] a;
      logic [15:0] d;
      for (int i = 0; i < 4; i++) begin
         a = 16'h0040 + 16'(2 * i);
         d = 16'h1111 * 16'(i + 1);
         drive(1'b0, 1'b1, a, d);
         checks++;
         if (stall !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL stream_wr_stall: addr %h stall=%b err=%b, required 0 0", a, stall, err);
         end
         model[int'(a)] = d;
         tick();
      end
      idle(4);
      for (int i = 0; i < 4; i++) begin
         a = 16'h0040 + 16'(2 * i);
         drive(1'b1, 1'b0, a, 16'h0);
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stream_rd_stall: addr %h stall=%b, required 0", a, stall);
         end
         sbq.push_back('{cyc + 2, model[int'(a)]});
         tick();
      end
      idle(4);
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b1, 16'h0048, 16'h4848);
      model[32'h48] = 16'h4848;
      tick();
      idle(4);
      drive(1'b1, 1'b0, 16'h0040, 16'h0);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_first: stall=%b, required 0", stall);
      end
      sbq.push_back('{cyc + 2, model[32'h40]});
      tick();
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 1'b0, 16'h0048, 16'h0);
         checks++;
         if (stall !== 1'b1 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_held: N+%0d stall=%b busy0=%b, required 1 1", k, stall, busy[0]);
         end
         tick();
      end
      drive(1'b1, 1'b0, 16'h0048, 16'h0);
      checks++;
      if (stall !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: N+4 stall=%b busy0=%b, required 0 0", stall, busy[0]);
      end
      sbq.push_back('{cyc + 2, model[32'h48]});
      tick();
      for (int k = 5; k <= 8; k++) begin
         drive(1'b0, 1'b0, 16'h0, 16'h0);
         checks++;
         if (busy[0] !== (k <= 7)) begin
            errors++;
            $display("FAIL busy_window: N+%0d busy0=%b, required %b", k, busy[0], (k <= 7));
         end
         tick();
      end
      idle(2);
   endtask

   task automatic test_illegal();
      drive(1'b0, 1'b1, 16'h0010, 16'h0F0F);
      model[32'h10] = 16'h0F0F;
      tick();
      idle(4);
      drive(1'b1, 1'b1, 16'h0010, 16'h1234);
      checks++;
      if (err !== 1'b1 || stall !== 1'b0 || busy !== 4'h0) begin
         errors++;
         $display("FAIL illegal_rdwr: err=%b stall=%b busy=%b, required 1 0 0000", err, stall, busy);
      end
      tick();
      drive(1'b1, 1'b0, 16'h0011, 16'h0);
      checks++;
      if (err !== 1'b1 || stall !== 1'b0 || busy !== 4'h0) begin
         errors++;
         $display("FAIL illegal_odd: err=%b stall=%b busy=%b, required 1 0 0000", err, stall, busy);
      end
      tick();
      idle(3);
      drive(1'b1, 1'b0, 16'h0010, 16'h0);
      checks++;
      if (err !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL illegal_followup: err=%b stall=%b, required 0 0", err, stall);
      end
      sbq.push_back('{cyc + 2, model[32'h10]});
      tick();
      drive(1'b1, 1'b0, 16'h0011, 16'h0);
      checks++;
      if (err !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL illegal_busy_bank: err=%b stall=%b, required 1 0", err, stall);
      end
      tick();
      idle(5);
   endtask

   task automatic test_row_alias();
      drive(1'b0, 1'b1, 16'h0002, 16'hA5A5);
      model[32'h2] = 16'hA5A5;
      tick();
      idle(4);
      drive(1'b0, 1'b1, 16'h0802, 16'hBEEF);
      model[32'h802] = 16'hBEEF;
      tick();
      idle(4);
      drive(1'b1, 1'b0, 16'h0802, 16'h0);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL alias_rd_hi: stall=%b, required 0", stall);
      end
      sbq.push_back('{cyc + 2, model[32'h802]});
      tick();
      idle(3);
      drive(1'b1, 1'b0, 16'h0002, 16'h0);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL alias_rd_lo: stall=%b, required 0", stall);
      end
      sbq.push_back('{cyc + 2, model[32'h2]});
      tick();
      idle(4);
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 16'h0040, 16'h0);
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if (data_valid !== 1'b0 || busy !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid: data_valid=%b busy=%b, required 0 0000", data_valid, busy);
      end
      tick();
      idle(2);
      drive(1'b1, 1'b0, 16'h0040, 16'h0);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_reread: stall=%b, required 0", stall);
      end
      sbq.push_back('{cyc + 2, 16'h1111});
      tick();
      idle(4);
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      logic [15:0] d;
      for (int i = 0; i < 4; i++) begin
         a = 16'h0840 + 16'(2 * i);
         d = 16'hC000 + 16'(i);
         drive(1'b0, 1'b1, a, d);
         checks++;
         if (stall !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wr: addr %h stall=%b err=%b, required 0 0", a, stall, err);
         end
         model[int'(a)] = d;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         a = 16'h0040 + 16'(2 * i);
         drive(1'b1, 1'b0, a, 16'h0);
         checks++;
         if (stall !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rd: addr %h stall=%b err=%b, required 0 0", a, stall, err);
         end
         sbq.push_back('{cyc + 2, model[int'(a)]});
         tick();
      end
      idle(5);
   endtask

   initial begin
      rst     = 1'b1;
      rd      = 1'b0;
      wr      = 1'b0;
      addr    = 16'h0;
      data_in = 16'h0;
      test_reset();
      test_bank_stream();
      test_stall();
      test_illegal();
      test_row_alias();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d reads outstanding, required 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
